issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//   Hazard controller for the dual-slot (upper/lower) decode stage. Tracks pending GPR writes
//   per register with countdown counters, and generates the decode `interlock` on RAW, WAW and
//   divider structural hazards. Sits beside decode: sees the same 64-bit bundle and the same
//   branch squash, and sequences bundle issue into execute.
// PARAMETERS
//   LAT_ALU   1   cycles until an Addi/Subi/Add/Sub/Srawi/Slawi/Li/Liw/Bl/Blrr/In* result is readable
//   LAT_LOAD  3   cycles until a Load result is readable
//   LAT_FPU   4   cycles for Fadd/Fsub/Fmul/Ftoi/Itof (pipelined unit)
//   LAT_FDIV  12  cycles for Fdiv/Fsqrt (single shared, non-pipelined unit)
//   CNT_W     localparam = $clog2(max(LAT_*)+1)
// PORTS
//   clk           in   1   clock
//   rstn          in   1   asynchronous active-low reset
//   dec_valid     in   1   dec_inst holds a real bundle this cycle
//   dec_inst      in   64  bundle: upper op [63:58], lower op [31:26], same field layout as decode
//   squash        in   1   branch_flag from decode; the bundle is discarded, not issued
//   interlock     out  1   combinational; decode must hold the bundle
//   stall_cause   out  3   {struct, waw, raw}; combinational, valid while interlock=1
//   busy_mask     out  32  registered; bit r = (cnt[r] != 0)
//   div_busy      out  1   registered; divider counter != 0
//   err_bundle    out  1   sticky; illegal bundle seen
//   stall_cycles  out  32  perf counter of cycles with dec_valid & interlock & ~squash
// BEHAVIOUR
//   Reset (async): all cnt[r]=0, div_cnt=0, err_bundle=0, stall_cycles=0.
//     Consequences: busy_mask=0, div_busy=0, and interlock=0 whenever dec_valid=0.
//   Issue: issue = dec_valid & ~interlock & ~squash.
//   Lower-slot nulling: the lower slot is treated as Nop when the upper op is
//     Liw/Jump/Blr/Bl/Blrr/Beq/Ble/Blt (Liw's [31:0] is an immediate).
//   Sources read, per slot:
//     a  for all ops except Li/Liw/Jump/Bl/Nop
//     b  for Add/Sub/Fadd/Fsub/Fmul/Fdiv/Fsqrt/Ftoi/Itof/Cmpd/Cmpf
//     s  for Store/Blrr/Outll
//     r31 for Blr
//   Destination: rt field, or r31 for Bl/Blrr. Only for ops that write a GPR (decode rt_flag
//     set, plus Load/FPU ops).
//   Hazards:
//     raw    = any read source r has cnt[r] != 0
//     waw    = any destination r has cnt[r] != 0
//     struct = slot op is Fdiv/Fsqrt and div_cnt != 0
//     interlock = dec_valid & ~squash & (raw|waw|struct)
//   Counters, every cycle:
//     cnt[r] <= issue-load ? L : (cnt[r] != 0 ? cnt[r]-1 : 0). An issue load overrides decrement.
//     Fdiv/Fsqrt issue also sets div_cnt = LAT_FDIV.
//   Timing: producer issued at cycle t with latency L -> dependent bundle issues no earlier
//     than t+L+1.
//   Intra-bundle: lower reading upper's rt is NOT a hazard (both read the GPR file in the same
//     cycle; the old value is seen).
//   Illegal bundles (both slots write the same rt, or both slots use the divider) set
//     err_bundle=1. The bundle still issues; the lower slot's load of the counters is dropped.
//   A squash while interlocked clears interlock in that same cycle; the counters keep decrementing.
//   stall_cycles wraps modulo 2^32.
// CONFIGURATION
//   SCOREBOARD_FWD_EN defined: ALU-class producers load LAT_ALU-1 (execute->decode bypass
//     exists), so a back-to-back ALU dependency issues with no stall when LAT_ALU=1.
//   Undefined: ALU-class producers load LAT_ALU; a back-to-back ALU dependency costs 1 stall.
//   Load/FPU/div latencies are unaffected by the macro.
// STRUCTURE
//   inst_package additions:
//     typedef enum lat_class_t {LC_NONE, LC_ALU, LC_LOAD, LC_FPU, LC_DIV}
//     function op_lat_class(op)
//     function op_reads(op) returning {rd_a, rd_b, rd_s, rd_lr}
//   One sub-module, slot_hazard: instantiated per slot; computes sources, destination, latency
//     class and raw/waw/struct from one 32-bit instruction plus cnt[] / div_cnt.
// TESTING
//   1. Add r3 issues; next bundle Addi r4<-r3: stall 1 cycle without FWD, 0 with FWD;
//      busy_mask[3] high for 1 cycle.
//   2. Load r5; then Add r6<-r5,r1: interlock=1, stall_cause=3'b001 for 3 cycles,
//      issues at t+4; stall_cycles=3.
//   3. Fdiv r7; then Fsqrt r8 (independent): stall_cause=3'b100 for 12 cycles;
//      div_busy falls at t+13.
//   4. Load r9, then Li r9 in the next bundle: stall_cause=3'b010 for 3 cycles.
//   5. Bundle {Add r2, Add r2}: err_bundle=1 and stays 1; cnt[2] loaded once;
//      pulse rstn low mid-stall -> every counter=0, interlock drops immediately.
//   6. Stalled Blr behind Bl (r31 busy) with squash=1 -> interlock=0 that cycle,
//      no counter load.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types, latencies and opcode decode helpers for the issue scoreboard.
// SCOREBOARD_FWD_EN: ALU-class producers assume an execute->decode bypass (one cycle shorter).
package issue_scoreboard_pkg;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 3;
    localparam int LAT_FPU  = 4;
    localparam int LAT_FDIV = 12;
    localparam int LAT_M1   = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
    localparam int LAT_M2   = (LAT_M1 > LAT_FPU) ? LAT_M1 : LAT_FPU;
    localparam int LAT_MAX  = (LAT_M2 > LAT_FDIV) ? LAT_M2 : LAT_FDIV;
    localparam int CNT_W    = $clog2(LAT_MAX + 1);

    // Field layout: op[31:26], rt/s[25:21], ra[20:16], rb[15:11]
    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,  OP_ADDI  = 6'd1,  OP_SUBI  = 6'd2,  OP_ADD   = 6'd3,
        OP_SUB   = 6'd4,  OP_SRAWI = 6'd5,  OP_SLAWI = 6'd6,  OP_LI    = 6'd7,
        OP_LIW   = 6'd8,  OP_BL    = 6'd9,  OP_BLRR  = 6'd10, OP_INLL  = 6'd11,
        OP_LOAD  = 6'd12, OP_STORE = 6'd13, OP_FADD  = 6'd14, OP_FSUB  = 6'd15,
        OP_FMUL  = 6'd16, OP_FDIV  = 6'd17, OP_FSQRT = 6'd18, OP_FTOI  = 6'd19,
        OP_ITOF  = 6'd20, OP_CMPD  = 6'd21, OP_CMPF  = 6'd22, OP_JUMP  = 6'd23,
        OP_BLR   = 6'd24, OP_BEQ   = 6'd25, OP_BLE   = 6'd26, OP_BLT   = 6'd27,
        OP_OUTLL = 6'd28
    } opcode_t;

    typedef enum logic [2:0] {
        LC_NONE = 3'd0, LC_ALU = 3'd1, LC_LOAD = 3'd2, LC_FPU = 3'd3, LC_DIV = 3'd4
    } lat_class_t;

    typedef struct packed {
        logic rd_a;
        logic rd_b;
        logic rd_s;
        logic rd_lr;
    } op_reads_t;

    function automatic lat_class_t op_lat_class(input logic [5:0] op);
        lat_class_t lc;
        case (op)
            OP_ADDI, OP_SUBI, OP_ADD, OP_SUB, OP_SRAWI, OP_SLAWI,
            OP_LI, OP_LIW, OP_BL, OP_BLRR, OP_INLL:         lc = LC_ALU;
            OP_LOAD:                                        lc = LC_LOAD;
            OP_FADD, OP_FSUB, OP_FMUL, OP_FTOI, OP_ITOF:    lc = LC_FPU;
            OP_FDIV, OP_FSQRT:                              lc = LC_DIV;
            default:                                        lc = LC_NONE;
        endcase
        return lc;
    endfunction

    function automatic op_reads_t op_reads(input logic [5:0] op);
        op_reads_t rd;
        rd = '{rd_a: 1'b0, rd_b: 1'b0, rd_s: 1'b0, rd_lr: 1'b0};
        case (op)
            OP_NOP, OP_LI, OP_LIW, OP_JUMP, OP_BL: rd.rd_a = 1'b0;
            OP_ADD, OP_SUB, OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
            OP_FTOI, OP_ITOF, OP_CMPD, OP_CMPF: begin
                rd.rd_a = 1'b1;
                rd.rd_b = 1'b1;
            end
            OP_STORE, OP_BLRR, OP_OUTLL: begin
                rd.rd_a = 1'b1;
                rd.rd_s = 1'b1;
            end
            OP_BLR: begin
                rd.rd_a  = 1'b1;
                rd.rd_lr = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SRAWI, OP_SLAWI, OP_INLL, OP_LOAD,
            OP_BEQ, OP_BLE, OP_BLT: rd.rd_a = 1'b1;
            default: rd.rd_a = 1'b0;
        endcase
        return rd;
    endfunction

    // Upper ops whose bundle carries no real lower instruction
    function automatic logic op_nulls_lower(input logic [5:0] op);
        logic n;
        case (op)
            OP_LIW, OP_JUMP, OP_BLR, OP_BL, OP_BLRR, OP_BEQ, OP_BLE, OP_BLT: n = 1'b1;
            default: n = 1'b0;
        endcase
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] lat_of(input lat_class_t lc);
        logic [CNT_W-1:0] l;
        case (lc)
`ifdef SCOREBOARD_FWD_EN
            LC_ALU:  l = CNT_W'(LAT_ALU - 1);
`else
            LC_ALU:  l = CNT_W'(LAT_ALU);
`endif
            LC_LOAD: l = CNT_W'(LAT_LOAD);
            LC_FPU:  l = CNT_W'(LAT_FPU);
            LC_DIV:  l = CNT_W'(LAT_FDIV);
            default: l = {CNT_W{1'b0}};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode <-> scoreboard bundle handshake and status signals.
interface issue_scoreboard_if;
    logic        dec_valid;
    logic [63:0] dec_inst;
    logic        squash;
    logic        interlock;
    logic [2:0]  stall_cause;
    logic [31:0] busy_mask;
    logic        div_busy;
    logic        err_bundle;
    logic [31:0] stall_cycles;

    modport master (
        output dec_valid, dec_inst, squash,
        input  interlock, stall_cause, busy_mask, div_busy, err_bundle, stall_cycles
    );
    modport slave (
        input  dec_valid, dec_inst, squash,
        output interlock, stall_cause, busy_mask, div_busy, err_bundle, stall_cycles
    );
endinterface

// File: rtl/issue_scoreboard_slot_hazard.sv
// Per-slot decode of sources/destination/latency and hazard detection against busy registers.
module issue_scoreboard_slot_hazard
    import issue_scoreboard_pkg::*;
(
    input  logic             en,
    input  logic [31:0]      inst,
    input  logic [31:0]      busy_v,
    input  logic             div_busy_v,
    output logic             raw_s,
    output logic             waw_s,
    output logic             strc_s,
    output logic             dest_vld_s,
    output logic [4:0]       dest_s,
    output logic [CNT_W-1:0] lat_s,
    output logic             is_div_s
);
    logic [5:0]  op_s;
    logic [4:0]  rt_s, ra_s, rb_s;
    op_reads_t   rd_s;
    lat_class_t  lc_s;
    logic        unused_s;

    assign op_s     = inst[31:26];
    assign rt_s     = inst[25:21];
    assign ra_s     = inst[20:16];
    assign rb_s     = inst[15:11];
    assign unused_s = ^inst[10:0];
    assign rd_s     = op_reads(op_s);
    assign lc_s     = op_lat_class(op_s);

    assign raw_s = en & ((rd_s.rd_a  & busy_v[ra_s]) |
                         (rd_s.rd_b  & busy_v[rb_s]) |
                         (rd_s.rd_s  & busy_v[rt_s]) |
                         (rd_s.rd_lr & busy_v[31]));

    // Link-writing branches target r31 instead of the rt field
    assign dest_s     = (op_s == OP_BL || op_s == OP_BLRR) ? 5'd31 : rt_s;
    assign dest_vld_s = en & (lc_s != LC_NONE);
    assign waw_s      = dest_vld_s & busy_v[dest_s];
    assign is_div_s   = en & (lc_s == LC_DIV);
    assign strc_s     = is_div_s & div_busy_v;
    assign lat_s      = lat_of(lc_s);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-slot issue scoreboard: per-GPR countdown counters, divider busy tracking and interlock.
// Build option SCOREBOARD_FWD_EN (see package) shortens ALU-class producer latency by one.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    issue_scoreboard_if.slave sb
);
    logic [CNT_W-1:0] cnt_r [32];
    logic [CNT_W-1:0] cnt_nxt_s [32];
    logic [CNT_W-1:0] div_cnt_r, div_nxt_s;
    logic [31:0]      busy_mask_r, busy_nxt_s;
    logic             div_busy_r;
    logic             err_bundle_r;
    logic [31:0]      stall_cycles_r;

    logic             up_raw_s, up_waw_s, up_strc_s, up_dvld_s, up_div_s;
    logic             lo_raw_s, lo_waw_s, lo_strc_s, lo_dvld_s, lo_div_s;
    logic [4:0]       up_dest_s, lo_dest_s;
    logic [CNT_W-1:0] up_lat_s, lo_lat_s;
    logic             lo_en_s, illegal_s, issue_s, up_load_s, lo_load_s, div_load_s;
    logic [2:0]       cause_s;

    assign lo_en_s = ~op_nulls_lower(sb.dec_inst[63:58]);

    issue_scoreboard_slot_hazard u_upper (
        .en(1'b1), .inst(sb.dec_inst[63:32]), .busy_v(busy_mask_r), .div_busy_v(div_busy_r),
        .raw_s(up_raw_s), .waw_s(up_waw_s), .strc_s(up_strc_s), .dest_vld_s(up_dvld_s),
        .dest_s(up_dest_s), .lat_s(up_lat_s), .is_div_s(up_div_s)
    );

    issue_scoreboard_slot_hazard u_lower (
        .en(lo_en_s), .inst(sb.dec_inst[31:0]), .busy_v(busy_mask_r), .div_busy_v(div_busy_r),
        .raw_s(lo_raw_s), .waw_s(lo_waw_s), .strc_s(lo_strc_s), .dest_vld_s(lo_dvld_s),
        .dest_s(lo_dest_s), .lat_s(lo_lat_s), .is_div_s(lo_div_s)
    );

    assign cause_s        = {up_strc_s | lo_strc_s, up_waw_s | lo_waw_s, up_raw_s | lo_raw_s};
    assign sb.interlock   = sb.dec_valid & ~sb.squash & (|cause_s);
    assign sb.stall_cause = sb.interlock ? cause_s : 3'b000;

    assign illegal_s  = (up_dvld_s & lo_dvld_s & (up_dest_s == lo_dest_s)) | (up_div_s & lo_div_s);
    assign issue_s    = sb.dec_valid & ~sb.interlock & ~sb.squash;
    assign up_load_s  = issue_s & up_dvld_s;
    assign lo_load_s  = issue_s & lo_dvld_s & ~illegal_s;
    assign div_load_s = issue_s & (up_div_s | (lo_div_s & ~illegal_s));

    // Next counter values: an issue load wins over decrement, upper slot wins over lower
    always_comb begin
        if (div_load_s) begin
            div_nxt_s = CNT_W'(LAT_FDIV);
        end else if (div_cnt_r != {CNT_W{1'b0}}) begin
            div_nxt_s = div_cnt_r - CNT_W'(1);
        end else begin
            div_nxt_s = {CNT_W{1'b0}};
        end
        for (int r = 0; r < 32; r++) begin
            if (up_load_s && up_dest_s == 5'(r)) begin
                cnt_nxt_s[r] = up_lat_s;
            end else if (lo_load_s && lo_dest_s == 5'(r)) begin
                cnt_nxt_s[r] = lo_lat_s;
            end else if (cnt_r[r] != {CNT_W{1'b0}}) begin
                cnt_nxt_s[r] = cnt_r[r] - CNT_W'(1);
            end else begin
                cnt_nxt_s[r] = {CNT_W{1'b0}};
            end
            busy_nxt_s[r] = (cnt_nxt_s[r] != {CNT_W{1'b0}});
        end
    end

    // Counter, status and perf-counter state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= {CNT_W{1'b0}};
            end
            div_cnt_r      <= {CNT_W{1'b0}};
            busy_mask_r    <= 32'd0;
            div_busy_r     <= 1'b0;
            err_bundle_r   <= 1'b0;
            stall_cycles_r <= 32'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
            div_cnt_r    <= div_nxt_s;
            busy_mask_r  <= busy_nxt_s;
            div_busy_r   <= (div_nxt_s != {CNT_W{1'b0}});
            err_bundle_r <= err_bundle_r | (issue_s & illegal_s);
            if (sb.dec_valid && sb.interlock) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign sb.busy_mask    = busy_mask_r;
    assign sb.div_busy     = div_busy_r;
    assign sb.err_bundle   = err_bundle_r;
    assign sb.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed testbench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

`ifdef SCOREBOARD_FWD_EN
    localparam int ALU_EFF = LAT_ALU - 1;
`else
    localparam int ALU_EFF = LAT_ALU;
`endif
    localparam logic ALU_BUSY = (ALU_EFF != 0);

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    issue_scoreboard_if sb();

    issue_scoreboard dut (.clk(clk), .rstn(rstn), .sb(sb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input opcode_t op, input int rt, input int ra, input int rb);
        return {6'(op), 5'(rt), 5'(ra), 5'(rb), 11'd0};
    endfunction

    task automatic drive(input logic [63:0] b, input logic sq);
        sb.dec_valid = 1'b1;
        sb.dec_inst  = b;
        sb.squash    = sq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sb.dec_valid = 1'b0;
        sb.dec_inst  = 64'd0;
        sb.squash    = 1'b0;
        #1;
        repeat (n) tick();
    endtask

    // Present a dependent bundle and count interlocked cycles until it issues
    task automatic run_dep(input logic [63:0] b, input logic [2:0] cause, input int nexp,
                           input string tag);
        int n;
        n = 0;
        drive(b, 1'b0);
        while (sb.interlock && n < 40) begin
            check_eq({tag, "_cause"}, 32'(sb.stall_cause), 32'(cause));
            tick();
            n++;
        end
        check_eq({tag, "_stalls"}, 32'(n), 32'(nexp));
    endtask

    initial begin
        rstn         = 1'b0;
        sb.dec_valid = 1'b0;
        sb.dec_inst  = 64'd0;
        sb.squash    = 1'b0;
        #12;
        check_eq("rst_busy", sb.busy_mask, 32'd0);
        check_eq("rst_div", 32'(sb.div_busy), 32'd0);
        check_eq("rst_err", 32'(sb.err_bundle), 32'd0);
        check_eq("rst_stalls", sb.stall_cycles, 32'd0);
        check_eq("rst_ilock", 32'(sb.interlock), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // 1: ALU producer followed by ALU consumer
        drive({mk(OP_ADD, 3, 1, 2), 32'd0}, 1'b0);
        check_eq("t1_issue", 32'(sb.interlock), 32'd0);
        tick();
        check_eq("t1_busy3", 32'(sb.busy_mask[3]), 32'(ALU_BUSY));
        run_dep({mk(OP_ADDI, 4, 3, 0), 32'd0}, 3'b001, ALU_EFF, "t1");
        tick();
        idle(3);

        // 2: load-use
        drive({mk(OP_LOAD, 5, 1, 0), 32'd0}, 1'b0);
        tick();
        run_dep({mk(OP_ADD, 6, 5, 1), 32'd0}, 3'b001, 3, "t2");
        tick();
        check_eq("t2_stall_cnt", sb.stall_cycles, 32'(ALU_EFF + 3));
        idle(4);

        // 3: divider structural hazard
        drive({mk(OP_FDIV, 7, 1, 2), 32'd0}, 1'b0);
        tick();
        check_eq("t3_divbusy", 32'(sb.div_busy), 32'd1);
        run_dep({mk(OP_FSQRT, 8, 1, 0), 32'd0}, 3'b100, 12, "t3");
        check_eq("t3_divfall", 32'(sb.div_busy), 32'd0);
        tick();
        check_eq("t3_divrearm", 32'(sb.div_busy), 32'd1);
        idle(14);

        // 4: WAW, then intra-bundle read of upper destination
        drive({mk(OP_LOAD, 9, 1, 0), 32'd0}, 1'b0);
        tick();
        run_dep({mk(OP_LI, 9, 0, 0), 32'd0}, 3'b010, 3, "t4");
        tick();
        drive({mk(OP_LOAD, 13, 1, 0), mk(OP_ADD, 14, 13, 1)}, 1'b0);
        check_eq("t4_intra", 32'(sb.interlock), 32'd0);
        tick();
        idle(4);

        // 5: illegal bundle (same rt), then async reset mid-stall
        drive({mk(OP_ADD, 2, 1, 1), mk(OP_LOAD, 2, 1, 0)}, 1'b0);
        check_eq("t5_issue", 32'(sb.interlock), 32'd0);
        tick();
        idle(0);
        check_eq("t5_err", 32'(sb.err_bundle), 32'd1);
        check_eq("t5_busy2", 32'(sb.busy_mask[2]), 32'(ALU_BUSY));
        tick();
        check_eq("t5_lo_drop", 32'(sb.busy_mask[2]), 32'd0);
        idle(3);
        check_eq("t5_sticky", 32'(sb.err_bundle), 32'd1);
        drive({mk(OP_LOAD, 10, 1, 0), 32'd0}, 1'b0);
        tick();
        drive({mk(OP_ADD, 11, 10, 1), 32'd0}, 1'b0);
        check_eq("t5_prestall", 32'(sb.interlock), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("t5_rst_ilock", 32'(sb.interlock), 32'd0);
        check_eq("t5_rst_busy", sb.busy_mask, 32'd0);
        check_eq("t5_rst_err", 32'(sb.err_bundle), 32'd0);
        check_eq("t5_rst_stalls", sb.stall_cycles, 32'd0);
        idle(0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // 6: link register, squash while interlocked
        drive({mk(OP_BL, 0, 0, 0), 32'd0}, 1'b0);
        tick();
        idle(0);
        check_eq("t6_bl_r31", 32'(sb.busy_mask[31]), 32'(ALU_BUSY));
        idle(2);
        drive({mk(OP_LOAD, 31, 1, 0), 32'd0}, 1'b0);
        tick();
        drive({mk(OP_BLR, 0, 0, 0), 32'd0}, 1'b1);
        check_eq("t6_sq_ilock", 32'(sb.interlock), 32'd0);
        check_eq("t6_sq_cause", 32'(sb.stall_cause), 32'd0);
        tick();
        drive({mk(OP_ADD, 12, 1, 2), 32'd0}, 1'b1);
        tick();
        check_eq("t6_sq_noload", sb.busy_mask, 32'h8000_0000);
        check_eq("t6_sq_nostall", sb.stall_cycles, 32'd0);
        run_dep({mk(OP_BLR, 0, 0, 0), 32'd0}, 3'b001, 1, "t6");
        tick();
        check_eq("t6_stall_cnt", sb.stall_cycles, 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
